// File: rtl/mem_access_stage.sv
// Memory-access stage: load/store bus transaction with lane steering, load extension and
// write-back select. Optional acknowledge timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic [31:0] result,
  input  logic [31:0] Data_store,
  input  logic        su,
  input  logic [1:0]  whb,
  input  logic [1:0]  wos,
  input  logic [31:0] PC_4,
  input  logic [31:0] immOut,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] wb_data,
  output logic        wb_valid,
  output logic        busy,
  output logic        misalign,
  output logic        timeout
);

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, sdata_q, pc4_q, imm_q, wb_q, wb_d;
  logic [1:0]  whb_q, wos_q;
  logic        su_q, load_q, store_q, misalign_q, misalign_d;
  logic        cap_en, in_load, in_store;

  function automatic logic [3:0] lane_be(logic [1:0] size, logic [1:0] a);
    case (size)
      2'b00:   lane_be = 4'b0001 << a;
      2'b01:   lane_be = 4'b0011 << a;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(logic [1:0] size, logic [1:0] a);
    is_misaligned = ((size == 2'b01) && a[0]) || (size[1] && (a != 2'b00));
  endfunction

  function automatic logic [31:0] lane_wdata(logic [1:0] size, logic [31:0] d);
    case (size)
      2'b00:   lane_wdata = {4{d[7:0]}};
      2'b01:   lane_wdata = {2{d[15:0]}};
      default: lane_wdata = d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(logic [31:0] rd, logic [1:0] a, logic [1:0] size,
                                           logic zext);
    logic [31:0] sh;
    sh = rd >> {a, 3'b000};
    case (size)
      2'b00:   load_ext = {{24{~zext & sh[7]}}, sh[7:0]};
      2'b01:   load_ext = {{16{~zext & sh[15]}}, sh[15:0]};
      default: load_ext = rd;
    endcase
  endfunction

  function automatic logic [31:0] wb_sel(logic [1:0] ws, logic [31:0] res, logic [31:0] ld,
                                         logic [31:0] pc4, logic [31:0] imm);
    case (ws)
      2'b00:   wb_sel = res;
      2'b01:   wb_sel = ld;
      2'b10:   wb_sel = pc4;
      default: wb_sel = imm;
    endcase
  endfunction

  assign in_load  = (opcode == OpLoad);
  assign in_store = (opcode == OpStore);
  assign cap_en   = (state_q == StIdle) && start;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  assign timeout = timeout_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    wb_d       = wb_q;
    misalign_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d      = '0;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          if (!(in_load || in_store)) begin
            state_d = StDone;
            wb_d    = wb_sel(wos, result, 32'h0, PC_4, immOut);
          end else if (is_misaligned(whb, result[1:0])) begin
            state_d    = StDone;
            wb_d       = 32'h0;
            misalign_d = 1'b1;
          end else begin
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
`ifdef MEM_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (dmem_ack) begin
          state_d = StDone;
          wb_d    = wb_sel(wos_q, addr_q,
                           load_q ? load_ext(dmem_rdata, addr_q[1:0], whb_q, su_q) : 32'h0,
                           pc4_q, imm_q);
`ifdef MEM_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = StDone;
          wb_d      = 32'h0;
          timeout_d = 1'b1;
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      wb_q       <= 32'h0;
      misalign_q <= 1'b0;
      addr_q     <= 32'h0;
      sdata_q    <= 32'h0;
      pc4_q      <= 32'h0;
      imm_q      <= 32'h0;
      whb_q      <= 2'b00;
      wos_q      <= 2'b00;
      su_q       <= 1'b0;
      load_q     <= 1'b0;
      store_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_q       <= wb_d;
      misalign_q <= misalign_d;
      if (cap_en) begin
        addr_q  <= result;
        sdata_q <= Data_store;
        pc4_q   <= PC_4;
        imm_q   <= immOut;
        whb_q   <= whb;
        wos_q   <= wos;
        su_q    <= su;
        load_q  <= in_load;
        store_q <= in_store;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
`endif

  // Bus outputs come from the captured instruction and are only driven during ACCESS.
  assign dmem_req   = (state_q == StAccess);
  assign dmem_we    = dmem_req && store_q;
  assign dmem_addr  = dmem_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign dmem_wdata = dmem_req ? lane_wdata(whb_q, sdata_q) : 32'h0;
  assign dmem_be    = dmem_req ? lane_be(whb_q, addr_q[1:0]) : 4'b0000;

  assign wb_data  = wb_q;
  assign wb_valid = (state_q == StDone);
  assign busy     = (state_q != StIdle);
  assign misalign = misalign_q;

endmodule
